// File: rtl/ldpc_encoder_if.sv
// Message-in / codeword-out handshake bundle for ldpc_encoder.
interface ldpc_encoder_if #(
    parameter int K          = 4,
    parameter int ROW_NUMBER = 8,
    parameter int WIDTH      = 8
);
    logic [K-1:0]                i_data;
    logic                        i_val;
    logic                        i_ready;
    logic                        o_ready;
    logic                        o_val;
    logic [ROW_NUMBER-1:0]       o_code;
    logic [WIDTH*ROW_NUMBER-1:0] o_llr;

    modport master (
        output i_data, i_val, i_ready,
        input  o_ready, o_val, o_code, o_llr
    );

    modport slave (
        input  i_data, i_val, i_ready,
        output o_ready, o_val, o_code, o_llr
    );
endinterface

// File: rtl/ldpc_encoder.sv
// Systematic LDPC encoder: one parity bit per CALC cycle, codeword held in DONE.
// Define LLR_OUT_EN to build the bit-to-LLR mapping on o_llr; otherwise o_llr is tied to 0.
module ldpc_encoder #(
    parameter int          ROW_NUMBER = 8,
    parameter int          COL_NUMBER = 4,
    parameter int          WIDTH      = 8,
    parameter int          LLR_MAG    = 4,
    parameter logic [15:0] P_MATRIX   = 16'hDBE7
) (
    input  logic          clk,
    input  logic          xrst,
    ldpc_encoder_if.slave bus
);
    localparam int K  = ROW_NUMBER - COL_NUMBER;
    localparam int CW = $clog2(COL_NUMBER) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(COL_NUMBER - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state, state_nxt;
    logic [K-1:0]          msg;
    logic [COL_NUMBER-1:0] parity, parity_nxt, par_all;
    logic [CW-1:0]         cnt;
    logic [ROW_NUMBER-1:0] code, code_nxt;

    always_ff @(posedge clk) begin
        if (!xrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_val)       state_nxt = CALC;
            CALC:    if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    if (bus.i_ready)     state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // All parity equations are formed in parallel; cnt picks the one stored this cycle.
    always_comb begin
        par_all    = '0;
        parity_nxt = parity;
        for (int j = 0; j < COL_NUMBER; j++) begin
            par_all[j] = ^(msg & P_MATRIX[j*K +: K]);
            if (cnt == CW'(j)) parity_nxt[j] = par_all[j];
        end
        code_nxt = {parity_nxt, msg};
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            msg    <= '0;
            parity <= '0;
            cnt    <= '0;
            code   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_val) begin
                        msg    <= bus.i_data;
                        parity <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    parity <= parity_nxt;
                    if (cnt == CNT_LAST) code <= code_nxt;
                    else                 cnt  <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready = (state == IDLE);
    assign bus.o_val   = (state == DONE);
    assign bus.o_code  = code;

`ifdef LLR_OUT_EN
    localparam logic [WIDTH-1:0] LLR_POS = WIDTH'(LLR_MAG);
    localparam logic [WIDTH-1:0] LLR_NEG = ~LLR_POS + WIDTH'(1);

    logic [WIDTH*ROW_NUMBER-1:0] llr, llr_nxt;

    always_comb begin
        llr_nxt = '0;
        for (int i = 0; i < ROW_NUMBER; i++)
            llr_nxt[WIDTH*i +: WIDTH] = code_nxt[i] ? LLR_NEG : LLR_POS;
    end

    always_ff @(posedge clk) begin
        if (!xrst)                                 llr <= '0;
        else if (state == CALC && cnt == CNT_LAST) llr <= llr_nxt;
    end

    assign bus.o_llr = llr;
`else
    assign bus.o_llr = '0;
`endif
endmodule

// File: tb/tb_ldpc_encoder.sv
// Directed vector bench for ldpc_encoder at default parameters.
module tb_ldpc_encoder;
    logic clk = 1'b0;
    logic xrst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ldpc_encoder_if #(.K(4), .ROW_NUMBER(8), .WIDTH(8)) bus ();

    ldpc_encoder dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0]  msg;
        logic [7:0]  code;
        logic [63:0] llr;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_llr(input logic [63:0] llr);
`ifdef LLR_OUT_EN
        return llr;
`else
        return 64'h0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a message, optionally pulse i_val during CALC, and return edges until o_val.
    task automatic send(input logic [3:0] m, input bit pulse_in_calc, output int lat);
        int n;
        n = 0;
        while (!bus.o_ready && n < 20) begin tick(); n++; end
        check("ready_before_send", {63'b0, bus.o_ready}, 64'h1);
        bus.i_data = m;
        bus.i_val  = 1'b1;
        tick();
        bus.i_val  = 1'b0;
        lat = 0;
        while (lat < 20) begin
            if (pulse_in_calc && lat == 1) begin
                bus.i_data = 4'b1010;
                bus.i_val  = 1'b1;
            end
            tick();
            bus.i_val = 1'b0;
            lat++;
            if (bus.o_val) break;
        end
    endtask

    task automatic release_done();
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        check("ready_after_release", {63'b0, bus.o_ready}, 64'h1);
        check("val_after_release", {63'b0, bus.o_val}, 64'h0);
    endtask

    initial begin
        int lat;
        logic [7:0] held;

        vecs[0] = '{4'b0001, 8'hD1, 64'hFCFC04FC040404FC};
        vecs[1] = '{4'b1111, 8'hFF, 64'hFCFCFCFCFCFCFCFC};
        vecs[2] = '{4'b0000, 8'h00, 64'h0404040404040404};
        vecs[3] = '{4'b0010, 8'h72, 64'h04FCFCFC0404FC04};
        vecs[4] = '{4'b1000, 8'hE8, 64'hFCFCFC04FC040404};

        xrst        = 1'b0;
        bus.i_data  = '0;
        bus.i_val   = 1'b0;
        bus.i_ready = 1'b0;
        repeat (3) tick();
        check("rst_ready", {63'b0, bus.o_ready}, 64'h1);
        check("rst_val",   {63'b0, bus.o_val},   64'h0);
        check("rst_code",  {56'b0, bus.o_code},  64'h0);
        check("rst_llr",   bus.o_llr,            64'h0);
        xrst = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            send(vecs[v].msg, 1'b0, lat);
            check("latency", 64'(lat), 64'd4);
            check("code", {56'b0, bus.o_code}, {56'b0, vecs[v].code});
            check("llr",  bus.o_llr, exp_llr(vecs[v].llr));
            check("ready_in_done", {63'b0, bus.o_ready}, 64'h0);
            release_done();
        end

        // DONE hold with i_ready low; i_val pulse during CALC must be ignored.
        send(4'b0001, 1'b1, lat);
        check("hold_latency", 64'(lat), 64'd4);
        check("hold_code", {56'b0, bus.o_code}, 64'hD1);
        held = bus.o_code;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("hold_val",  {63'b0, bus.o_val}, 64'h1);
            check("hold_code_stable", {56'b0, bus.o_code}, {56'b0, held});
        end
        check("hold_llr", bus.o_llr, exp_llr(64'hFCFC04FC040404FC));
        release_done();
        repeat (6) tick();
        check("no_queued_msg", {63'b0, bus.o_val}, 64'h0);
        check("idle_ready", {63'b0, bus.o_ready}, 64'h1);

        // Reset at the second CALC edge discards the in-flight message.
        bus.i_data = 4'b0001;
        bus.i_val  = 1'b1;
        tick();
        bus.i_val  = 1'b0;
        tick();
        xrst = 1'b0;
        tick();
        check("midrst_val",   {63'b0, bus.o_val},   64'h0);
        check("midrst_code",  {56'b0, bus.o_code},  64'h0);
        check("midrst_llr",   bus.o_llr,            64'h0);
        check("midrst_ready", {63'b0, bus.o_ready}, 64'h1);
        xrst = 1'b1;
        check("ready_after_rst", {63'b0, bus.o_ready}, 64'h1);
        send(4'b1111, 1'b0, lat);
        check("post_rst_latency", 64'(lat), 64'd4);
        check("post_rst_code", {56'b0, bus.o_code}, 64'hFF);
        check("post_rst_llr", bus.o_llr, exp_llr(64'hFCFCFCFCFCFCFCFC));
        release_done();

        // Back-to-back: accept, 4 CALC, release, next accept = 6 clocks per codeword.
        send(4'b0000, 1'b0, lat);
        bus.i_ready = 1'b1;
        bus.i_data  = 4'b1111;
        bus.i_val   = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        tick();
        bus.i_val   = 1'b0;
        lat = 0;
        while (lat < 20) begin tick(); lat++; if (bus.o_val) break; end
        check("b2b_latency", 64'(lat), 64'd4);
        check("b2b_code", {56'b0, bus.o_code}, 64'hFF);
        release_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
